// File: rtl/count_sequencer_if.sv
// Bundles the frame-control inputs, the flex_counter handshake and the strobe
// outputs of count_sequencer; master drives stimulus/counter, slave is the sequencer.
interface count_sequencer_if #(
    parameter int NUM_CNT_BITS = 4
);
    logic                    start;
    logic                    abort;
    logic [NUM_CNT_BITS-1:0] bit_period;
    logic [NUM_CNT_BITS-1:0] num_bits;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    rollover_flag;
    logic                    cnt_clear;
    logic                    cnt_enable;
    logic [NUM_CNT_BITS-1:0] cnt_rollover_val;
    logic                    sample_strobe;
    logic                    bit_done;
    logic                    frame_done;
    logic                    busy;
    logic [NUM_CNT_BITS-1:0] bit_index;

    modport master (
        output start, abort, bit_period, num_bits, count_out, rollover_flag,
        input  cnt_clear, cnt_enable, cnt_rollover_val, sample_strobe,
               bit_done, frame_done, busy, bit_index
    );

    modport slave (
        input  start, abort, bit_period, num_bits, count_out, rollover_flag,
        output cnt_clear, cnt_enable, cnt_rollover_val, sample_strobe,
               bit_done, frame_done, busy, bit_index
    );
endinterface

// File: rtl/count_sequencer.sv
// Frame sequencer in front of flex_counter: num_bits bit periods with mid-bit and
// end-of-bit strobes. Define COUNT_SEQUENCER_STOP_BIT_EN to append one stop period.
module count_sequencer #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic               CLK,
    input  logic               nRST,
    count_sequencer_if.slave   bus
);
    localparam int W = NUM_CNT_BITS;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DONE  = 3'd4;
`ifdef COUNT_SEQUENCER_STOP_BIT_EN
    localparam logic [2:0] STOP  = 3'd3;
`endif

    logic [2:0]   state_q, state_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] nbits_q, nbits_d;
    logic [W-1:0] idx_q, idx_d;

    logic         clear_c, enable_c, sample_c, bit_done_c, frame_done_c;
    logic         mid_hit, last_bit;

    // A zero period would never roll the counter over, so it is treated as one tick.
    function automatic logic [W-1:0] clamp_period(input logic [W-1:0] p);
        clamp_period = (p == '0) ? {{(W-1){1'b0}}, 1'b1} : p;
    endfunction

    // One extra bit keeps (P+1) from wrapping when P is all ones.
    function automatic logic [W:0] mid_point(input logic [W-1:0] p);
        logic [W:0] sum;
        sum       = {1'b0, p} + {{W{1'b0}}, 1'b1};
        mid_point = sum >> 1;
    endfunction

    assign mid_hit  = ({1'b0, bus.count_out} == mid_point(period_q));
    assign last_bit = (idx_q == (nbits_q - {{(W-1){1'b0}}, 1'b1}));

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        nbits_d      = nbits_q;
        idx_d        = idx_q;
        clear_c      = 1'b0;
        enable_c     = 1'b0;
        sample_c     = 1'b0;
        bit_done_c   = 1'b0;
        frame_done_c = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (bus.start && !bus.abort) begin
                    period_d = clamp_period(bus.bit_period);
                    nbits_d  = bus.num_bits;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                clear_c = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                enable_c   = 1'b1;
                sample_c   = mid_hit;
                bit_done_c = bus.rollover_flag;
                if (bus.rollover_flag) begin
                    if (last_bit) begin
`ifdef COUNT_SEQUENCER_STOP_BIT_EN
                        state_d = STOP;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d = idx_q + {{(W-1){1'b0}}, 1'b1};
                    end
                end
            end
`ifdef COUNT_SEQUENCER_STOP_BIT_EN
            STOP: begin
                enable_c = 1'b1;
                sample_c = mid_hit;
                if (bus.rollover_flag) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                frame_done_c = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything: park the counter in clear and silence strobes.
        if (bus.abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            idx_d        = '0;
            clear_c      = 1'b1;
            enable_c     = 1'b0;
            sample_c     = 1'b0;
            bit_done_c   = 1'b0;
            frame_done_c = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            period_q <= '0;
            nbits_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            nbits_q  <= nbits_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.cnt_clear        = clear_c;
    assign bus.cnt_enable       = enable_c;
    assign bus.cnt_rollover_val = period_q;
    assign bus.sample_strobe    = sample_c;
    assign bus.bit_done         = bit_done_c;
    assign bus.frame_done       = frame_done_c;
    assign bus.busy             = (state_q != IDLE);
    assign bus.bit_index        = idx_q;
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural flex_counter; per-cycle
// strobe maps are compared against hand-derived bit masks (bit k = cycle k).
module tb_count_sequencer;
    localparam int W = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    count_sequencer_if #(.NUM_CNT_BITS(W)) bus ();

    count_sequencer #(.NUM_CNT_BITS(W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Behavioural flex_counter: wraps to 1 after rollover_val, flag aligned with the top count.
    logic [W-1:0] cnt_q;
    logic         flag_q;
    logic [W-1:0] cnt_nxt;
    assign cnt_nxt = (cnt_q == bus.cnt_rollover_val) ? 4'd1 : cnt_q + 4'd1;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (bus.cnt_clear) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (bus.cnt_enable) begin
            cnt_q  <= cnt_nxt;
            flag_q <= (cnt_nxt == bus.cnt_rollover_val);
        end
    end
    assign bus.count_out     = cnt_q;
    assign bus.rollover_flag = flag_q;

`ifdef COUNT_SEQUENCER_STOP_BIT_EN
    localparam logic [63:0] A_SMP  = 64'h490,   A_FD  = 64'h1000,   A_BUSY = 64'h1FFE,   A_EN = 64'hFFC;
    localparam logic [63:0] Z_SMP  = 64'hFFFF8, Z_FD  = 64'h100000, Z_BUSY = 64'h1FFFFE;
    localparam logic [63:0] F_SMP  = 64'h11110, F_FD  = 64'h80000,  F_BUSY = 64'hFFFFE;
    localparam int          DONE_C = 12;
`else
    localparam logic [63:0] A_SMP  = 64'h90,    A_FD  = 64'h200,    A_BUSY = 64'h3FE,    A_EN = 64'h1FC;
    localparam logic [63:0] Z_SMP  = 64'h7FFF8, Z_FD  = 64'h80000,  Z_BUSY = 64'hFFFFE;
    localparam logic [63:0] F_SMP  = 64'h1110,  F_FD  = 64'h8000,   F_BUSY = 64'hFFFE;
    localparam int          DONE_C = 9;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0]  m_clr, m_en, m_smp, m_bd, m_fd, m_busy;
    logic [W-1:0] idx_log [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic [W-1:0] p, input logic [W-1:0] n);
        bus.bit_period = p;
        bus.num_bits   = n;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    // Records cycles 1..n of a frame; optional abort, stray starts and a period change.
    task automatic capture(input int n, input int abort_c, input int s1, input int s2,
                           input int bpc, input logic [W-1:0] bpv);
        m_clr = '0; m_en = '0; m_smp = '0; m_bd = '0; m_fd = '0; m_busy = '0;
        for (int c = 1; c <= n; c++) begin
            bus.abort = (c == abort_c);
            bus.start = (c == s1) || (c == s2);
            if (c == bpc) bus.bit_period = bpv;
            #1;
            m_clr[c]   = bus.cnt_clear;
            m_en[c]    = bus.cnt_enable;
            m_smp[c]   = bus.sample_strobe;
            m_bd[c]    = bus.bit_done;
            m_fd[c]    = bus.frame_done;
            m_busy[c]  = bus.busy;
            idx_log[c] = bus.bit_index;
            @(posedge CLK);
            #1;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.bit_period = '0;
        bus.num_bits = '0;
        #12;
        check("reset_outputs", {58'd0, bus.busy, bus.cnt_clear, bus.cnt_enable,
              bus.sample_strobe, bus.bit_done, bus.frame_done}, 64'd0);
        check("reset_rollover_val", {60'd0, bus.cnt_rollover_val}, 64'd0);
        nRST = 1'b1;
        tick();

        // P=3, N=2
        start_frame(4'd3, 4'd2);
        capture(14, 0, 0, 0, 0, 4'd0);
        check("p3n2_clear", m_clr, 64'h2);
        check("p3n2_enable", m_en, A_EN);
        check("p3n2_sample", m_smp, A_SMP);
        check("p3n2_bitdone", m_bd, 64'h120);
        check("p3n2_framedone", m_fd, A_FD);
        check("p3n2_busy", m_busy, A_BUSY);
        check("p3n2_idx_c5", {60'd0, idx_log[5]}, 64'd0);
        check("p3n2_idx_c6", {60'd0, idx_log[6]}, 64'd1);
        check("p3n2_rollover_val", {60'd0, bus.cnt_rollover_val}, 64'd3);

        // P=0, N=0 behaves as P=1, N=16
        start_frame(4'd0, 4'd0);
        capture(22, 0, 0, 0, 0, 4'd0);
        check("p0n0_bitdone", m_bd, 64'h7FFF8);
        check("p0n0_sample", m_smp, Z_SMP);
        check("p0n0_framedone", m_fd, Z_FD);
        check("p0n0_busy", m_busy, Z_BUSY);
        check("p0n0_rollover_val", {60'd0, bus.cnt_rollover_val}, 64'd1);

        // Abort at the first sample strobe of P=4, N=3, then a full frame
        start_frame(4'd4, 4'd3);
        capture(8, 4, 0, 0, 0, 4'd0);
        check("abort_clear", m_clr, 64'h12);
        check("abort_enable", m_en, 64'hC);
        check("abort_strobes", m_smp | m_bd | m_fd, 64'd0);
        check("abort_busy", m_busy, 64'h1E);
        start_frame(4'd4, 4'd3);
        capture(22, 0, 0, 0, 0, 4'd0);
        check("p4n3_sample", m_smp, F_SMP);
        check("p4n3_bitdone", m_bd, 64'h4440);
        check("p4n3_framedone", m_fd, F_FD);
        check("p4n3_busy", m_busy, F_BUSY);

        // Stray starts mid-frame and at the end, period changed mid-frame
        start_frame(4'd3, 4'd2);
        capture(16, 0, 6, DONE_C, 4, 4'd5);
        check("ign_sample", m_smp, A_SMP);
        check("ign_bitdone", m_bd, 64'h120);
        check("ign_framedone", m_fd, A_FD);
        check("ign_busy", m_busy, A_BUSY);
        check("ign_rollover_val", {60'd0, bus.cnt_rollover_val}, 64'd3);

        // Asynchronous reset in the middle of the second bit
        start_frame(4'd3, 4'd2);
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_bitdone", {63'd0, bus.bit_done}, 64'd1);
        check("pre_reset_idx", {60'd0, bus.bit_index}, 64'd1);
        nRST = 1'b0;
        #1;
        check("async_reset_all", {50'd0, bus.cnt_clear, bus.cnt_enable, bus.sample_strobe,
              bus.bit_done, bus.frame_done, bus.busy, bus.bit_index, bus.cnt_rollover_val}, 64'd0);
        nRST = 1'b1;
        tick();
        check("post_reset_busy", {63'd0, bus.busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_sequencer.md
# count_sequencer

Control stage directly upstream of `flex_counter`. It drives the counter's `clear`, `count_enable` and `rollover_val` inputs, and consumes its `count_out` and `rollover_flag` outputs. It sequences one frame of `num_bits` bit periods, each `bit_period` counter ticks long. Per bit it emits a mid-bit sample strobe and an end-of-bit strobe, and it flags frame completion to the downstream shift/capture logic.

## Interface
- `NUM_CNT_BITS`, default 4: width of the counter-side buses, `bit_period` and `num_bits`.
- `CLK`  in  1  system clock, rising-edge active.
- `nRST`  in  1  reset, asynchronous and active-low.
- `start`  in  1  frame request; sampled only in IDLE.
- `abort`  in  1  synchronous frame kill; highest priority.
- `bit_period`  in  NUM_CNT_BITS  ticks per bit; 0 is treated as 1.
- `num_bits`  in  NUM_CNT_BITS  bits per frame; 0 means 2^NUM_CNT_BITS.
- `count_out`  in  NUM_CNT_BITS  from the counter.
- `rollover_flag`  in  1  from the counter.
- `cnt_clear`  out  1  to counter `clear`.
- `cnt_enable`  out  1  to counter `count_enable`.
- `cnt_rollover_val`  out  NUM_CNT_BITS  to counter `rollover_val`; driven from the latched period register.
- `sample_strobe`  out  1  one-cycle pulse at mid-bit.
- `bit_done`  out  1  one-cycle pulse at end of each bit.
- `frame_done`  out  1  one-cycle pulse after the last bit.
- `busy`  out  1  high in every state except IDLE.
- `bit_index`  out  NUM_CNT_BITS  index of the current bit, starting at 0.

## Operation
- **States:** IDLE, CLEAR, RUN, STOP (macro only), DONE.
- **IDLE:**
  - If `start`=1, latch the period as max(`bit_period`,1) and latch `num_bits`.
  - Zero `bit_index`, then go to CLEAR.
- **CLEAR:** `cnt_clear`=1 and `cnt_enable`=0. Always goes to RUN.
- **RUN:**
  - `cnt_enable`=1.
  - `sample_strobe` = (`count_out` == (P+1)>>1), where P is the latched period.
  - `bit_done` = `rollover_flag`.
  - On `rollover_flag`, if `bit_index` == `num_bits`-1 (mod 2^NUM_CNT_BITS), go to STOP (macro) or DONE. Otherwise increment `bit_index`.
- **DONE:** `frame_done`=1 and `cnt_enable`=0. Always goes to IDLE.
- **`start` outside IDLE:** ignored. This includes `start` during DONE; a back-to-back frame needs `start` held into IDLE.
- **`abort`:** from any non-IDLE state, the next state is IDLE.
  - In the abort cycle, `cnt_clear`=1 and `cnt_enable`=0.
  - `sample_strobe`, `bit_done` and `frame_done` are forced to 0.
- **Input changes:** `bit_period` and `num_bits` changes mid-frame have no effect; only the latched copies are used.
- **Output logic:** `cnt_clear`, `cnt_enable` and the strobes are decoded combinationally from state and counter inputs. State, `bit_index` and the latches are registers.

## Timing
- **Reset:** `nRST` low forces state IDLE and zeroes the latches, so `cnt_rollover_val`=0. It also zeroes `bit_index`, `busy`, `cnt_clear`, `cnt_enable` and all strobes. It takes effect immediately and asynchronously, mid-frame included.
- **Cycle numbering:** cycle 0 is the edge where `start` is sampled.
- **Frame schedule:**
  - Cycle 1 is CLEAR.
  - Cycle 2 is RUN with `count_out`=0, a lead cycle.
  - Each bit then spans P cycles with `count_out` running 1..P.
  - DONE follows the cycle in which the last `rollover_flag` is seen.
- **Busy duration:** N·P+3 cycles without the macro; N·P+P+3 with it.
- **P=1:** `count_out` stays at 1, so `sample_strobe` and `bit_done` are high on every RUN cycle.

## Configuration
- **`COUNT_SEQUENCER_STOP_BIT_EN` defined:**
  - After the last data bit, enter STOP for one extra period P with `cnt_enable`=1.
  - In STOP, `sample_strobe` fires at mid-bit and `bit_done` stays 0.
  - `rollover_flag` moves the FSM to DONE.
  - `abort` applies as in RUN.
- **Undefined:** no STOP state; RUN goes directly to DONE.

## Test plan
- **Reset:** assert `nRST` mid-RUN → all outputs read 0 within the same cycle, and `busy` reads 0 after release.
- **P=3, N=2, macro off:** pulse `start` → `cnt_clear` at cycle 1, `sample_strobe` at cycles 4 and 7, `bit_done` at cycles 5 and 8, `frame_done` at cycle 9, `busy` over cycles 1–9.
- **P=0, N=0, NUM_CNT_BITS=4:** behaves as P=1, N=16 → 16 `bit_done` pulses on consecutive cycles, then `frame_done`.
- **Abort:** `abort` at the first `sample_strobe` of P=4, N=3 → `cnt_clear`=1 for that cycle, no further strobes, IDLE next cycle; a new `start` then runs a full frame.
- **Ignored start and latching:** pulse `start` during RUN and during DONE, and change `bit_period` mid-frame → exactly one frame runs, with its timing unchanged.
- **Macro on, P=3, N=2:** one extra `sample_strobe` at cycle 10, then `frame_done` at cycle 12.
